// File: rtl/dcache_direct_mapped.sv
// Write-back direct-mapped data cache: 8 lines x 4 bytes, CPU byte port, 32-bit block memory port.
// Latency: read hit 0 cycles; miss = 1 + FETCH cycles + 1 UPDATE (+ WRITEBACK cycles if victim dirty).
// Backpressure: busywait stalls the CPU on a miss; mem_busywait stalls WRITEBACK/FETCH exit.
module dcache_direct_mapped (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2,
        S_UPDATE    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_valid;
    logic [7:0]  r_dirty;
    logic [2:0]  r_tag  [8];
    logic [31:0] r_data [8];

    // Set on the edge that enters a memory phase; memory raises mem_busywait
    // combinationally from our request, so the entry edge must not count as done.
    logic        r_first;
    logic [31:0] r_fill;

    logic [2:0]  w_tag;
    logic [2:0]  w_index;
    logic [1:0]  w_offset;
    logic        w_access;
    logic        w_hit;
    logic        w_victim_dirty;
    logic        w_mem_done;
    logic [31:0] w_line;
    logic [7:0]  w_sel_byte;

    assign w_tag          = address[7:5];
    assign w_index        = address[4:2];
    assign w_offset       = address[1:0];
    assign w_access       = read ^ write;
    assign w_line         = r_data[w_index];
    assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_victim_dirty = r_valid[w_index] && r_dirty[w_index];
    assign w_mem_done     = !r_first && !mem_busywait;
    assign w_sel_byte     = w_line[{w_offset, 3'b000} +: 8];

    // Next-state and all outputs; reset forces every output low without a clock.
    always_comb begin
        w_state_next  = r_state;
        readdata      = 8'h00;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'h00;
        mem_writedata = 32'h0000_0000;
        if (reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_hit) begin
                            if (read) begin
                                readdata = w_sel_byte;
                            end
                        end else begin
                            busywait     = 1'b1;
                            w_state_next = w_victim_dirty ? S_WRITEBACK : S_FETCH;
                        end
                    end
                end
                S_WRITEBACK: begin
                    busywait      = 1'b1;
                    mem_write     = 1'b1;
                    mem_address   = {r_tag[w_index], w_index};
                    mem_writedata = w_line;
                    if (w_mem_done) begin
                        w_state_next = S_FETCH;
                    end
                end
                S_FETCH: begin
                    busywait    = 1'b1;
                    mem_read    = 1'b1;
                    mem_address = address[7:2];
                    if (w_mem_done) begin
                        w_state_next = S_UPDATE;
                    end
                end
                default: begin
                    busywait     = 1'b1;
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // State register, first-cycle flag and fetched-block capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_first <= 1'b0;
            r_fill  <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            r_first <= (w_state_next != r_state);
            if (r_state == S_FETCH && w_mem_done) begin
                r_fill <= mem_readdata;
            end
        end
    end

    // Line array: write-hit byte merge in IDLE, whole-line refill in UPDATE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 8'h00;
            r_dirty <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                r_tag[i]  <= 3'd0;
                r_data[i] <= 32'h0000_0000;
            end
        end else begin
            if (r_state == S_IDLE && w_access && w_hit && write) begin
                r_data[w_index][{w_offset, 3'b000} +: 8] <= writedata;
                r_dirty[w_index]                         <= 1'b1;
            end
            if (r_state == S_UPDATE) begin
                r_data[w_index]  <= r_fill;
                r_tag[w_index]   <= w_tag;
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped with a fixed-latency block memory model.
// Memory answers after 5 busy cycles per request; stimulus changes 1ns after posedge.
// Outputs are sampled on the falling edge or between edges for async reset checks.
module tb_dcache_direct_mapped;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int total;
    int passed;

    dcache_direct_mapped dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Block memory: busy for 5 cycles from each new request, then completes.
    logic [31:0] mem [64];
    logic [2:0]  cnt;
    logic        mem_init;

    assign mem_busywait = (mem_read || mem_write) && (cnt < 3'd5);
    assign mem_readdata = mem[mem_address];

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[1]  <= 32'hDDCCBBAA;
            mem[9]  <= 32'h44332211;
            mem[18] <= 32'hA1B2C3D4;
        end else if (mem_write && !mem_busywait) begin
            mem[mem_address] <= mem_writedata;
        end
        if (!(mem_read || mem_write) || !mem_busywait) cnt <= 3'd0;
        else cnt <= cnt + 3'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
        read      = rd;
        write     = wr;
        address   = a;
        writedata = wd;
    endtask

    // Entered at the first falling edge of a memory phase; leaves at the first
    // falling edge where the request is gone.
    task automatic run_phase(input string name, input bit is_wr, input logic [5:0] exp_addr,
                             input logic [31:0] exp_wd, input int exp_n);
        int n;
        bit both;
        n    = 0;
        both = 1'b0;
        while (((is_wr ? mem_write : mem_read) === 1'b1) && n < 60) begin
            if (n == 0) begin
                chk({name, " addr"}, {26'd0, mem_address}, {26'd0, exp_addr});
                if (is_wr) chk({name, " wdata"}, mem_writedata, exp_wd);
            end
            if (mem_read && mem_write) both = 1'b1;
            n++;
            @(negedge clock);
        end
        chk({name, " cycles"}, n, exp_n);
        chk({name, " rd_wr_overlap"}, {31'd0, both}, 32'd0);
    endtask

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       exp_busy;
        logic       chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        total    = 0;
        passed   = 0;
        mem_init = 1'b1;
        reset    = 1'b0;
        drive(1'b1, 1'b0, 8'h05, 8'h00);

        // Line 1 holds DDCCBBAA after the clean miss below.
        vecs[0] = '{1'b0, 1'b1, 8'h06, 8'h5A, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[2] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 8'hBB};
        vecs[3] = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 1'b1, 8'hAA};
        vecs[4] = '{1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b1, 8'hDD};
        vecs[5] = '{1'b1, 1'b1, 8'h25, 8'h77, 1'b0, 1'b0, 8'h00};

        // Test 1: reset for two cycles with a request pending.
        @(posedge clock);
        #1 mem_init = 1'b0;
        @(negedge clock);
        chk("rst busywait", {31'd0, busywait}, 32'd0);
        chk("rst mem_read", {31'd0, mem_read}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        chk("idle outputs", {readdata, busywait, mem_read, mem_write, mem_address}, 32'd0);
        chk("idle mem_writedata", mem_writedata, 32'd0);
        chk("idle state", {30'd0, dut.r_state}, 32'd0);
        chk("idle valid", {24'd0, dut.r_valid}, 32'd0);
        chk("idle dirty", {24'd0, dut.r_dirty}, 32'd0);

        // Test 2: clean read miss at 0x05.
        @(posedge clock);
        #1 drive(1'b1, 1'b0, 8'h05, 8'h00);
        @(negedge clock);
        chk("miss1 busy idle", {31'd0, busywait}, 32'd1);
        chk("miss1 no mem idle", {30'd0, mem_read, mem_write}, 32'd0);
        @(negedge clock);
        chk("miss1 no write", {31'd0, mem_write}, 32'd0);
        run_phase("miss1 fetch", 1'b0, 6'h01, 32'h0, 6);
        chk("miss1 update", {busywait, mem_read, mem_write}, 32'd4);
        @(negedge clock);
        chk("miss1 busy", {31'd0, busywait}, 32'd0);
        chk("miss1 rdata", {24'd0, readdata}, 32'h0000_00BB);

        // Tests 3 and 5: hits and an illegal request, one cycle each.
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1 drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            @(negedge clock);
            chk($sformatf("vec%0d busy", i), {31'd0, busywait}, {31'd0, vecs[i].exp_busy});
            chk($sformatf("vec%0d mem", i), {30'd0, mem_read, mem_write}, 32'd0);
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d rdata", i), {24'd0, readdata}, {24'd0, vecs[i].exp_rd});
        end
        @(posedge clock);
        #1 drive(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        chk("line1 dirty", {31'd0, dut.r_dirty[1]}, 32'd1);
        chk("line1 data", dut.r_data[1], 32'hDD5ABBAA);
        chk("line1 tag", {29'd0, dut.r_tag[1]}, 32'd0);
        chk("illegal state", {30'd0, dut.r_state}, 32'd0);

        // Test 4: dirty eviction by a read of 0x25.
        @(posedge clock);
        #1 drive(1'b1, 1'b0, 8'h25, 8'h00);
        @(negedge clock);
        chk("evict busy idle", {31'd0, busywait}, 32'd1);
        @(negedge clock);
        run_phase("evict wb", 1'b1, 6'h01, 32'hDD5ABBAA, 6);
        run_phase("evict fetch", 1'b0, 6'h09, 32'h0, 6);
        chk("evict update", {busywait, mem_read, mem_write}, 32'd4);
        @(negedge clock);
        chk("evict busy", {31'd0, busywait}, 32'd0);
        chk("evict rdata", {24'd0, readdata}, 32'h0000_0022);
        chk("evict tag", {29'd0, dut.r_tag[1]}, 32'd1);
        chk("evict dirty", {31'd0, dut.r_dirty[1]}, 32'd0);
        chk("evict mem1", mem[1], 32'hDD5ABBAA);
        @(posedge clock);
        #1 drive(1'b0, 1'b0, 8'h00, 8'h00);

        // Test 6: asynchronous reset in the middle of FETCH.
        @(posedge clock);
        #1 drive(1'b1, 1'b0, 8'h48, 8'h00);
        @(negedge clock);
        @(negedge clock);
        chk("arst fetch active", {31'd0, mem_read}, 32'd1);
        chk("arst fetch addr", {26'd0, mem_address}, 32'h12);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("arst mem_read", {31'd0, mem_read}, 32'd0);
        chk("arst busywait", {31'd0, busywait}, 32'd0);
        chk("arst mem_address", {26'd0, mem_address}, 32'd0);
        chk("arst valid", {24'd0, dut.r_valid}, 32'd0);
        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        chk("arst remiss busy", {31'd0, busywait}, 32'd1);
        chk("arst remiss idle", {30'd0, mem_read, mem_write}, 32'd0);
        @(negedge clock);
        run_phase("arst fetch", 1'b0, 6'h12, 32'h0, 6);
        @(negedge clock);
        chk("arst rdata", {24'd0, readdata}, 32'h0000_00D4);
        chk("arst busy done", {31'd0, busywait}, 32'd0);
        @(posedge clock);
        #1 drive(1'b0, 1'b0, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
Write-back, direct-mapped data cache between the CPU's data-access port and the block-oriented data memory. It serves CPU byte reads and writes from 8 lines of 4 bytes each. On a miss it stalls the CPU via busywait, writes back a dirty victim block, then fetches the missing block. It is upstream of the data memory and drives that memory's read/write/busywait handshake at 32-bit block granularity.

Parameters:
NUM_LINES, 8, number of cache lines; fixed geometry, index width 3
BLOCK_BYTES, 4, bytes per line; fixed geometry, offset width 2
TAG_W, 3, tag width, equal to 8 - 3 - 2

Ports:
clock  input  1  system clock; all state changes occur on its rising edge
reset  input  1  asynchronous, active-low reset
read  input  1  CPU read request, held until busywait is low
write  input  1  CPU write request, held until busywait is low
address  input  8  CPU byte address, split as tag[7:5], index[4:2], offset[1:0]
writedata  input  8  CPU write byte
readdata  output  8  CPU read byte
busywait  output  1  CPU stall
mem_read  output  1  block read request to memory
mem_write  output  1  block write request to memory
mem_address  output  6  block address {tag, index}
mem_writedata  output  32  block to write back; byte k sits at bits [8k+7:8k]
mem_readdata  input  32  fetched block, same byte packing
mem_busywait  input  1  memory busy

Behaviour:
- Per-line storage: valid, dirty, tag[2:0], data[31:0].
- Reset (reset=0), applied immediately and regardless of clock:
  - all valid and dirty bits cleared; state set to IDLE.
  - readdata, busywait, mem_read, mem_write, mem_address and mem_writedata all forced to 0.
  - Reset mid-miss abandons the transaction; mem_read and mem_write drop at once; no line is updated.
- Request decoding:
  - Access = read XOR write.
  - read and write both high is illegal: treated as no access, busywait stays 0, no state change.
- hit = valid[index] AND tag[index] == address[7:5], computed combinationally.
- IDLE, read hit:
  - readdata = selected byte, combinational.
  - busywait = 0; zero-cycle stall.
- IDLE, write hit:
  - busywait = 0.
  - On the next rising clock edge: the byte at the offset is written, dirty is set to 1, and the tag is unchanged.
- IDLE, miss: busywait = 1 combinationally. On the next clock edge go to WRITEBACK if the victim is valid and dirty, else to FETCH.
- WRITEBACK:
  - mem_write = 1, mem_address = {victim tag, index}, mem_writedata = victim data.
  - Leave at the first clock edge where mem_busywait = 0, provided the request has been held for at least one full cycle. A first-cycle flag blocks the entry edge, because memory raises mem_busywait combinationally from the request.
  - Next state FETCH.
- FETCH:
  - mem_read = 1, mem_address = address[7:2].
  - Same exit rule as WRITEBACK; next state UPDATE.
  - mem_readdata is captured on the exit edge.
- UPDATE (1 cycle):
  - Line written with data = captured block, tag = address[7:5], valid = 1, dirty = 0.
  - busywait stays 1; next state IDLE.
- Back in IDLE, the held request now hits:
  - a read returns data and busywait falls combinationally;
  - a write is merged on the following edge with dirty = 1.
- busywait = 1 in every state except IDLE. In IDLE it is 1 only for a valid access that misses.
- mem_read and mem_write are never high together. Both are 0 in IDLE and UPDATE.
- The CPU must hold address, writedata, read and write stable while busywait = 1; the cache does not latch them.
- Miss latency, clean victim: 1 (IDLE) + FETCH cycles + 1 (UPDATE) + the hit cycle. A dirty victim adds the WRITEBACK cycles.

Test Plan:
1. Reset low for 2 cycles, then release -> all outputs 0, all lines invalid, state IDLE.
2. Clean read miss: read address 8'h05. Memory returns 32'hDDCCBBAA after 5 busy cycles -> mem_read=1 with mem_address=6'h01, mem_write=0, then UPDATE. readdata=8'hBB, and busywait falls in the cycle after UPDATE.
3. Write hit: write 8'h5A to 8'h06 after test 2 -> busywait stays 0. A later read of 8'h06 returns 8'h5A with no memory traffic, and line 1 is dirty.
4. Dirty eviction: read 8'h25 (tag 1, index 1) -> mem_write with mem_address=6'h01 and mem_writedata=32'hDD5ABBAA, then mem_read with mem_address=6'h09. The line ends with tag=1 and dirty=0.
5. Illegal request: read=write=1 -> busywait=0, mem_read=mem_write=0, no array change.
6. Async reset asserted during FETCH -> mem_read drops to 0 without a clock edge. After release, a read of the same address misses again.
